alien_shot_scheduler: RTL
=========================

Name: alien_shot_scheduler

Overview:
- Consumes the free-running pseudo-random word from the random position generator and decides when and from which alien column the next enemy shot is fired.
- Waits a randomised number of frames, then selects a living column starting from a random index.
- Issues a valid/ready request carrying the column and its screen X to the downstream enemy-shot unit.

Parameters:
- N_COLS, 11, number of alien columns.
- COL_W, 4, width of column index; must hold N_COLS-1.
- BITS_RND, 11, width of random input.
- MIN_DELAY, 20, minimum frames between shots; must be >= 1.
- DELAY_SPAN, 32, random delay range; delay = MIN_DELAY + (rnd % DELAY_SPAN).
- X_W, 11, width of screen X output.
- X_ORIGIN, 40, X pixel of column 0 left edge.
- COL_PITCH, 48, pixel pitch between columns.
- MAX_SHOTS, 3, outstanding-shot limit (only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- game_active  in  1  high while a wave is in play.
- tick_frame  in  1  one-cycle pulse per video frame.
- random_in  in  BITS_RND  random word, sampled only where stated.
- alive_mask  in  N_COLS  bit c=1 means column c has a living alien.
- shot_ready  in  1  shot unit accepts the request.
- shot_done  in  1  one-cycle pulse when a fired shot leaves the screen or hits; ignored without the optional feature.
- shot_valid  out  1  request pending.
- shot_col  out  COL_W  selected column.
- shot_x  out  X_W  X_ORIGIN + shot_col*COL_PITCH + COL_PITCH/2.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; shot_valid=0; shot_col=0; shot_x=0; busy=0; delay counter=0; scan index and scan count=0.
- States: IDLE, WAIT, PICK, REQUEST. All outputs are registered.
- IDLE → WAIT when game_active=1. On that cycle the counter loads MIN_DELAY + (random_in % DELAY_SPAN). The same reload rule applies on every entry into WAIT.
- WAIT:
  - Counter decrements on each tick_frame.
  - On a tick_frame with counter==1: go to PICK, latching idx = random_in % N_COLS and scan count = 0.
  - Ticks are counted only in WAIT; tick_frame is ignored in PICK and REQUEST.
- PICK (one column checked per cycle):
  - If alive_mask[idx]=1: latch shot_col=idx, compute shot_x, go to REQUEST. shot_valid=1 from the next cycle.
  - Otherwise: idx wraps N_COLS-1 → 0, and scan count increments.
  - After N_COLS misses (all columns dead): go to WAIT with reload; no request is issued.
  - Maximum PICK duration is N_COLS cycles.
- REQUEST:
  - shot_valid, shot_col and shot_x are held stable until shot_ready=1 is sampled with shot_valid=1.
  - Transfer occurs on that edge. shot_valid=0 on the following cycle, and the FSM goes to WAIT with reload.
- game_active=0 in any state → IDLE on the next edge, with shot_valid cleared. Abort mid-handshake is legal, and the shot unit must not count an unacknowledged request.
- Simultaneous game_active=0 and shot_ready=1 in REQUEST: the abort wins; no transfer.
- Arithmetic:
  - Modulo and shot_x are computed with width extended to 16 bits, then truncated to X_W.
  - The parameter choice guarantees shot_x < 2^X_W.

Optional Feature:
- Macro: ALIEN_SHOT_LIMIT_EN.
- With the macro defined:
  - A counter of outstanding shots increments on each transfer and decrements on each shot_done pulse.
  - Simultaneous transfer and shot_done leave the count unchanged.
  - The count saturates at 0 and MAX_SHOTS.
  - WAIT does not exit to PICK while count==MAX_SHOTS; the counter holds at 1 until a slot frees.
  - The count resets to 0 on reset_n or on entry to IDLE.
- Without the macro: no counter; shot_done is unused; no limit on outstanding shots.

Test Plan:
1. Assert reset_n=0 mid-REQUEST → shot_valid=0, shot_col=0, shot_x=0, busy=0 immediately, without waiting for clk.
2. game_active=1, random_in held 5, alive_mask all ones → counter loads 25; shot_valid rises 2 cycles after the 25th tick_frame; shot_col=5, shot_x=40+240+24=304.
3. Start index 10 (random_in=10), alive_mask=0b00000000100 → wrap scan 10,0,1,2; shot_col=2, shot_x=160; shot_valid asserted after 4 PICK cycles.
4. alive_mask=0 → no shot_valid ever; FSM returns to WAIT after 11 PICK cycles and reloads.
5. shot_ready held 0 for 7 cycles in REQUEST → shot_valid, shot_col and shot_x stable throughout; shot_ready=1 → shot_valid=0 on the next cycle. Separately, game_active=0 mid-REQUEST → IDLE, shot_valid=0, no transfer.
6. With ALIEN_SHOT_LIMIT_EN, MAX_SHOTS=3: three transfers, no shot_done → no fourth shot_valid across 200 frames; one shot_done pulse → next shot issued at the following tick_frame.

Source files
------------

// File: rtl/alien_shot_scheduler.sv
// Enemy shot scheduler: waits a random number of frames, scans for a living alien column
// starting at a random index, then issues a valid/ready shot request.
// Optional define ALIEN_SHOT_LIMIT_EN caps the number of shots in flight at MAX_SHOTS.
//
// state   | meaning
// IDLE    | no wave in play, outputs cleared
// WAIT    | counting frames down to the next shot
// PICK    | scanning columns for a living alien, one per cycle
// REQUEST | shot request pending until the shot unit accepts it
module alien_shot_scheduler #(
  parameter int N_COLS     = 11,
  parameter int COL_W      = 4,
  parameter int BITS_RND   = 11,
  parameter int MIN_DELAY  = 20,
  parameter int DELAY_SPAN = 32,
  parameter int X_W        = 11,
  parameter int X_ORIGIN   = 40,
  parameter int COL_PITCH  = 48,
  parameter int MAX_SHOTS  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                game_active,
  input  logic                tick_frame,
  input  logic [BITS_RND-1:0] random_in,
  input  logic [N_COLS-1:0]   alive_mask,
  input  logic                shot_ready,
  input  logic                shot_done,
  output logic                shot_valid,
  output logic [COL_W-1:0]    shot_col,
  output logic [X_W-1:0]      shot_x,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WAIT, PICK, REQUEST} state_t;

  state_t           state;
  logic [15:0]      delay_cnt;
  logic [COL_W-1:0] idx;
  logic [COL_W-1:0] scan_cnt;
  logic [15:0]      rnd16;
  logic [15:0]      delay_load;
  logic             xfer;
  logic             limit_full;

  assign rnd16      = 16'(random_in);
  assign delay_load = 16'(MIN_DELAY) + (rnd16 % 16'(DELAY_SPAN));
  // The abort takes priority over a same-cycle ready, so no transfer is seen then.
  assign xfer       = (state == REQUEST) && shot_valid && shot_ready && game_active;

`ifdef ALIEN_SHOT_LIMIT_EN
  localparam int OW = $clog2(MAX_SHOTS + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_SHOTS);

  logic [OW-1:0] outstanding;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (!game_active || state == IDLE) begin
      outstanding <= '0;
    end else if (xfer && !shot_done) begin
      if (outstanding != MAX_O) outstanding <= outstanding + 1'b1;
    end else if (shot_done && !xfer) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

  assign limit_full = (outstanding == MAX_O);
`else
  logic unused_limit;
  assign unused_limit = shot_done | (MAX_SHOTS == 0);
  assign limit_full   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      delay_cnt  <= '0;
      idx        <= '0;
      scan_cnt   <= '0;
      shot_valid <= 1'b0;
      shot_col   <= '0;
      shot_x     <= '0;
      busy       <= 1'b0;
    end else if (!game_active) begin
      state      <= IDLE;
      shot_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= WAIT;
          delay_cnt <= delay_load;
          busy      <= 1'b1;
        end
        WAIT: begin
          if (tick_frame) begin
            if (delay_cnt == 16'd1) begin
              // While the shot limit is reached the count parks at 1.
              if (!limit_full) begin
                state    <= PICK;
                idx      <= COL_W'(rnd16 % 16'(N_COLS));
                scan_cnt <= '0;
              end
            end else begin
              delay_cnt <= delay_cnt - 16'd1;
            end
          end
        end
        PICK: begin
          if (alive_mask[idx]) begin
            state      <= REQUEST;
            shot_col   <= idx;
            shot_x     <= X_W'(16'(X_ORIGIN) + 16'(idx) * 16'(COL_PITCH) + 16'(COL_PITCH / 2));
            shot_valid <= 1'b1;
          end else if (scan_cnt == COL_W'(N_COLS - 1)) begin
            state     <= WAIT;
            delay_cnt <= delay_load;
          end else begin
            idx      <= (idx == COL_W'(N_COLS - 1)) ? '0 : idx + 1'b1;
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        REQUEST: begin
          if (xfer) begin
            state      <= WAIT;
            shot_valid <= 1'b0;
            delay_cnt  <= delay_load;
          end
        end
        default: begin
          state      <= IDLE;
          shot_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
